// File: rtl/result_demux.sv
// Routes each accepted result word into one of two independent 2-entry FIFO channels.
// Channel index 1 is output port A (sel=1) and index 0 is port B (sel=0).
module result_demux #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             sel,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
    output logic [CNT_W-1:0] a_count,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data,
    output logic [CNT_W-1:0] b_count
);

    // Encoding puts "not empty" in bit 0 and "full" in bit 1, so both flags come straight off a flop.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } occ_t;

    logic [1:0]       w_full;
    logic [1:0]       w_valid;
    logic [1:0]       w_ready;
    logic [1:0]       w_push;
    logic [WIDTH-1:0] w_data  [2];
    logic [CNT_W-1:0] w_count [2];

    // Acceptance depends only on the selected channel's fill level, never on downstream ready.
    assign in_ready = ~w_full[sel];
    assign w_push   = {in_valid & in_ready & sel, in_valid & in_ready & ~sel};
    assign w_ready  = {a_ready, b_ready};

    for (genvar g = 0; g < 2; g++) begin : g_chan
        occ_t             r_state;
        logic [WIDTH-1:0] r_head;
        logic [WIDTH-1:0] r_tail;
        logic [CNT_W-1:0] r_count;
        logic             w_pop;

        assign w_pop = r_state[0] & w_ready[g];

        // NOTE: head/tail words are reset too, because the data outputs must read 0 during reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= EMPTY;
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                // NOTE: non-blocking assignments so every flop samples pre-edge values.
                if (w_pop) begin
                    r_count <= r_count + CNT_W'(1);
                end
                case (r_state)
                    EMPTY: begin
                        if (w_push[g]) begin
                            r_head  <= in_data;
                            r_state <= ONE;
                        end
                    end
                    ONE: begin
                        if (w_push[g] && w_pop) begin
                            r_head <= in_data;
                        end else if (w_push[g]) begin
                            r_tail  <= in_data;
                            r_state <= FULL;
                        end else if (w_pop) begin
                            r_state <= EMPTY;
                        end
                    end
                    FULL: begin
                        if (w_pop) begin
                            r_head  <= r_tail;
                            r_state <= ONE;
                        end
                    end
                    default: r_state <= EMPTY;
                endcase
            end
        end

        assign w_valid[g] = r_state[0];
        assign w_full[g]  = r_state[1];
        assign w_data[g]  = r_head;
        assign w_count[g] = r_count;
    end

    assign a_valid = w_valid[1];
    assign a_data  = w_data[1];
    assign a_count = w_count[1];
    assign b_valid = w_valid[0];
    assign b_data  = w_data[0];
    assign b_count = w_count[0];

endmodule

// File: tb/tb_result_demux.sv
// Directed bench for result_demux: routing, backpressure, same-cycle push/pop,
// counter wrap and mid-operation reset, against hand-computed expectations.
module tb_result_demux;

    localparam int WIDTH = 32;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             sel;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] a_data;
    logic [CNT_W-1:0] a_count;
    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] b_data;
    logic [CNT_W-1:0] b_count;

    int total = 0;
    int bad   = 0;

    result_demux #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .sel      (sel),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .a_count  (a_count),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data),
        .b_count  (b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        sel      = 1'b0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        #3;
        check("rst_a_valid", a_valid, 0);
        check("rst_b_valid", b_valid, 0);
        check("rst_a_data", a_data, 0);
        check("rst_b_data", b_data, 0);
        check("rst_a_count", a_count, 0);
        check("rst_b_count", b_count, 0);
        check("rst_in_ready", in_ready, 1);
        tick();
        rst_n = 1'b1;

        // Single word to A with 1-cycle latency, then popped.
        sel = 1'b1; in_data = 32'h1111_1111; in_valid = 1'b1; a_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t1_a_valid", a_valid, 1);
        check("t1_a_data", a_data, 32'h1111_1111);
        check("t1_b_valid", b_valid, 0);
        check("t1_a_count_pre", a_count, 0);
        tick();
        check("t1_a_count", a_count, 1);
        check("t1_a_empty", a_valid, 0);

        // Fill A under backpressure; third word must be refused.
        a_ready = 1'b0; sel = 1'b1; in_valid = 1'b1; in_data = 32'hA0;
        tick();
        in_data = 32'hA1;
        tick();
        in_data = 32'hA2;
        #1;
        check("t2_ready_full", in_ready, 0);
        tick();
        check("t2_hold_data", a_data, 32'hA0);
        check("t2_hold_valid", a_valid, 1);

        // A stays FULL while a sel=0 word flows through B.
        sel = 1'b0; in_data = 32'hB0; b_ready = 1'b1;
        #1;
        check("t3_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("t3_b_valid", b_valid, 1);
        check("t3_b_data", b_data, 32'hB0);
        check("t3_a_data", a_data, 32'hA0);
        tick();
        check("t3_b_count", b_count, 1);
        check("t3_b_empty", b_valid, 0);

        // Drain A while re-offering A2: order A0, A1, A2.
        sel = 1'b1; in_data = 32'hA2; in_valid = 1'b1; a_ready = 1'b1;
        #1;
        check("t2_still_full", in_ready, 0);
        tick();
        check("t2_out1", a_data, 32'hA1);
        check("t2_cnt1", a_count, 2);
        tick();
        in_valid = 1'b0;
        check("t2_out2", a_data, 32'hA2);
        check("t2_cnt2", a_count, 3);
        tick();
        check("t2_cnt3", a_count, 4);
        check("t2_a_empty", a_valid, 0);

        // B ONE with B1, then push B2 and pop in the same cycle.
        b_ready = 1'b0; sel = 1'b0; in_valid = 1'b1; in_data = 32'hB1;
        tick();
        check("t4_b_head", b_data, 32'hB1);
        in_data = 32'hB2; b_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t4_b_valid", b_valid, 1);
        check("t4_b_data", b_data, 32'hB2);
        check("t4_b_count", b_count, 2);
        tick();
        check("t4_b_count2", b_count, 3);
        check("t4_b_empty", b_valid, 0);

        // Push into A while both channels pop in the same cycle.
        a_ready = 1'b0; b_ready = 1'b0;
        sel = 1'b1; in_valid = 1'b1; in_data = 32'hC1;
        tick();
        sel = 1'b0; in_data = 32'hD1;
        tick();
        sel = 1'b1; in_data = 32'hC2; a_ready = 1'b1; b_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t5_a_data", a_data, 32'hC2);
        check("t5_a_count", a_count, 5);
        check("t5_b_valid", b_valid, 0);
        check("t5_b_count", b_count, 4);
        tick();
        check("t5_a_count2", a_count, 6);

        // Stream through A until a_count reaches 65535, then one more transfer wraps it.
        sel = 1'b1; in_valid = 1'b1; a_ready = 1'b1; in_data = 32'h5000_0000;
        tick();
        for (int i = 0; i < 65529; i++) begin
            in_data = 32'h5000_0001 + i;
            tick();
        end
        in_valid = 1'b0;
        check("t6_a_count_max", a_count, 16'hFFFF);
        check("t6_a_valid", a_valid, 1);
        tick();
        check("t6_a_count_wrap", a_count, 0);
        check("t6_a_empty", a_valid, 0);

        // Fill both channels, then reset mid-operation.
        a_ready = 1'b0; b_ready = 1'b0; in_valid = 1'b1;
        sel = 1'b1; in_data = 32'hE0; tick();
        in_data = 32'hE1; tick();
        sel = 1'b0; in_data = 32'hF0; tick();
        in_data = 32'hF1; tick();
        in_valid = 1'b0;
        check("t7_a_full", a_valid, 1);
        check("t7_b_full", b_valid, 1);
        check("t7_b_count", b_count, 4);
        check("t7_in_ready_full", in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_rst_a_valid", a_valid, 0);
        check("t7_rst_b_valid", b_valid, 0);
        check("t7_rst_a_count", a_count, 0);
        check("t7_rst_b_count", b_count, 0);
        check("t7_rst_a_data", a_data, 0);
        check("t7_rst_in_ready", in_ready, 1);
        a_ready = 1'b1; b_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("t7_post_a_valid", a_valid, 0);
        check("t7_post_b_valid", b_valid, 0);
        check("t7_post_a_count", a_count, 0);
        check("t7_post_b_count", b_count, 0);

        // Normal operation resumes after reset release.
        sel = 1'b1; in_valid = 1'b1; in_data = 32'h6060_6060;
        tick();
        in_valid = 1'b0;
        check("t8_a_valid", a_valid, 1);
        check("t8_a_data", a_data, 32'h6060_6060);
        tick();
        check("t8_a_count", a_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/result_demux.md
RESULT_DEMUX -- requirements
Module: result_demux

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data path width in bits.
REQ-002 SHALL have parameter CNT_W, default 16, width of each per-output transfer counter.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in_valid  input  1  source offers in_data.
REQ-007 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  result word to route.
REQ-009 SHALL have port sel  input  1  destination select: 1 routes to port a, 0 routes to port b; qualified by in_valid.
REQ-010 SHALL have ports a_valid / b_valid  output  1 each  head entry of that channel is valid.
REQ-011 SHALL have ports a_ready / b_ready  input  1 each  sink accepts the head entry.
REQ-012 SHALL have ports a_data / b_data  output  WIDTH each  head entry of that channel.
REQ-013 SHALL have ports a_count / b_count  output  CNT_W each  completed output transfers per channel.

Function
REQ-014 SHALL contain two independent 2-entry FIFO channels, A and B, each with occupancy state EMPTY, ONE or FULL.
REQ-015 SHALL perform an input transfer when in_valid and in_ready are both 1 at a rising edge, and SHALL write in_data into channel A if sel=1, else channel B.
REQ-016 SHALL drive in_ready = (sel ? A not FULL : B not FULL); in_ready SHALL NOT depend combinationally on a_ready or b_ready.
REQ-017 SHALL perform an output transfer on a channel when x_valid and x_ready are both 1 at a rising edge, removing the head entry.
REQ-018 SHALL drive x_valid = 1 exactly when channel x is not EMPTY, and x_data = head entry, both directly from registers.
REQ-019 SHALL present a word accepted at edge N on x_valid/x_data after edge N, i.e. 1-cycle latency when the channel was EMPTY.
REQ-020 SHALL preserve per-channel order; there is no ordering guarantee between channels.
REQ-021 SHALL apply these occupancy transitions per channel: EMPTY+push->ONE; ONE+push->FULL; ONE+pop->EMPTY; FULL+pop->ONE; ONE+push+pop->ONE, with the new word becoming head; all other cases hold state.
REQ-022 SHALL allow a push into one channel and pops from both channels in the same cycle.
REQ-023 SHALL keep x_data stable while x_valid=1 and x_ready=0.
REQ-024 SHALL increment x_count by 1 on each output transfer of channel x, wrapping from 2^CNT_W-1 to 0.
REQ-025 SHALL ignore in_data and sel when in_valid=0; sel changing while in_valid=1 and in_ready=0 is legal and re-evaluates in_ready.

Reset
REQ-026 SHALL, while rst_n=0, force both channels EMPTY, a_valid=b_valid=0, a_data=b_data=0, a_count=b_count=0; in_ready then follows REQ-016 and reads 1.
REQ-027 SHALL discard buffered entries on reset asserted mid-operation, without producing an output transfer for them.
REQ-028 SHALL resume normal operation at the first rising edge after rst_n deasserts.

Verification
REQ-029 SHALL be checked with: in_data=0x11111111, sel=1, one cycle; a_ready=1 -> a_valid=1, a_data=0x11111111 the next cycle, b_valid stays 0, a_count=1 after the pop.
REQ-030 SHALL be checked with: a_ready=0 and three sel=1 words 0xA0, 0xA1, 0xA2 offered -> the first two are accepted, in_ready=0 on the third; after a_ready=1 the outputs are 0xA0, 0xA1, 0xA2 in order.
REQ-031 SHALL be checked with: channel A FULL and b_ready=1, then a sel=0 word 0xB0 -> in_ready=1, b_data=0xB0 the next cycle, A contents unchanged.
REQ-032 SHALL be checked with: channel B ONE holding 0xB1, a push of 0xB2 and a pop in the same cycle -> B stays ONE, b_data=0xB2, b_count increments by 1.
REQ-033 SHALL be checked with: a_count preloaded by 65535 transfers, then one more transfer -> a_count=0.
REQ-034 SHALL be checked with: rst_n pulsed low while both channels are FULL -> both x_valid=0 and both counts 0 immediately, with no spurious transfers after release.
